// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: state encodings and channel geometry.
package decoder_scan_ctrl_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a host and the scan sequencer.
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    import decoder_scan_ctrl_pkg::*;

    logic                start;
    logic                stop;
    logic                continuous;
    logic [NUM_CH-1:0]   chan_mask;
    logic [DWELL_W-1:0]  dwell;
    logic [CH_W-1:0]     A;
    logic                E;
    logic                busy;
    logic                sweep_done;

    modport master (
        output start, stop, continuous, chan_mask, dwell,
        input  A, E, busy, sweep_done
    );

    modport slave (
        input  start, stop, continuous, chan_mask, dwell,
        output A, E, busy, sweep_done
    );

endinterface

// File: rtl/decoder_scan_ctrl_chan_next_sel.sv
// Next-channel picker: lowest set mask bit strictly above cur, else lowest set bit overall.
// Latency: combinational.
// Backpressure: none.
module chan_next_sel
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   nxt,
    output logic              found_above,
    output logic              any
);

    logic [CH_W-1:0] w_above;
    logic [CH_W-1:0] w_lowest;
    logic            w_found;

    // Walk downward so the last hit written is the lowest qualifying bit.
    always_comb begin
        w_above  = '0;
        w_lowest = '0;
        w_found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_lowest = CH_W'(i);
                if (i > int'(cur)) begin
                    w_above = CH_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign nxt         = w_found ? w_above : w_lowest;
    assign found_above = w_found;
    assign any         = |mask;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving A/E of a 3-to-8 decoder: dwell per channel, blanking gap, mask skip.
// Latency: E rises one cycle after an accepted start; all outputs registered.
// Backpressure: none; start is dropped unless idle, stop aborts at once.
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
)(
    input  logic               clk,
    input  logic               rst_n,
    decoder_scan_ctrl_if.slave scan
);

    localparam int              BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BLK_W-1:0] BLK_LD = BLK_W'(BLANK_CYCLES);

    state_t             r_state;
    logic [CH_W-1:0]    r_a;
    logic [CH_W-1:0]    r_nxt;
    logic               r_e;
    logic               r_busy;
    logic               r_sweep_done;
    logic               r_cont;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [BLK_W-1:0]   r_blank_cnt;

    logic [CH_W-1:0]    w_cur;
    logic [CH_W-1:0]    w_nxt;
    logic               w_found;
    logic               w_any;
    logic               w_last;
    logic               w_go;
    logic [DWELL_W-1:0] w_dwell_ld;

    // From idle, asking for "above the top channel" yields the lowest set bit.
    assign w_cur = (r_state == ST_IDLE) ? CH_W'(NUM_CH - 1) : r_a;

    chan_next_sel u_sel (
        .mask        (scan.chan_mask),
        .cur         (w_cur),
        .nxt         (w_nxt),
        .found_above (w_found),
        .any         (w_any)
    );

    assign w_dwell_ld = (scan.dwell == '0) ? DWELL_W'(1) : scan.dwell;
    assign w_last     = (r_dwell_cnt == DWELL_W'(1));
    assign w_go       = w_found || (r_cont && w_any);

    // The next channel is chosen as the dwell ends; a blank gap only delays loading it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_nxt        <= '0;
            r_e          <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_cont       <= 1'b0;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
        end else begin
            r_sweep_done <= 1'b0;
            if (scan.stop) begin
                r_state <= ST_IDLE;
                r_e     <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (scan.start && w_any) begin
                            r_state     <= ST_ACTIVE;
                            r_a         <= w_nxt;
                            r_e         <= 1'b1;
                            r_busy      <= 1'b1;
                            r_dwell_cnt <= w_dwell_ld;
                            r_cont      <= scan.continuous;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!w_last) begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end else begin
                            r_sweep_done <= !w_found;
                            if (!w_go) begin
                                r_state <= ST_IDLE;
                                r_e     <= 1'b0;
                                r_busy  <= 1'b0;
                            end else if (BLANK_CYCLES == 0) begin
                                r_a         <= w_nxt;
                                r_dwell_cnt <= w_dwell_ld;
                            end else begin
                                r_state     <= ST_BLANK;
                                r_e         <= 1'b0;
                                r_blank_cnt <= BLK_LD;
                                r_nxt       <= w_nxt;
                            end
                        end
                    end
                    ST_BLANK: begin
                        if (r_blank_cnt == BLK_W'(1)) begin
                            r_state     <= ST_ACTIVE;
                            r_a         <= r_nxt;
                            r_e         <= 1'b1;
                            r_dwell_cnt <= w_dwell_ld;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - BLK_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_e     <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign scan.A          = r_a;
    assign scan.E          = r_e;
    assign scan.busy       = r_busy;
    assign scan.sweep_done = r_sweep_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: a 2-cycle-blank build and a no-blank build side by side.
module tb_decoder_scan_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_scan_ctrl_if #(.DWELL_W(8)) if2 ();
    decoder_scan_ctrl_if #(.DWELL_W(8)) if0 ();

    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .scan(if2));
    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .scan(if0));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         sel;
        logic       start, stop, cont;
        logic [7:0] mask, dwell;
        logic [2:0] a;
        logic       e, busy, sd;
    } vec_t;

    vec_t tbl[$];
    int   n_t2;

    function automatic vec_t mkv(bit sel, logic start, logic stop, logic cont, logic [7:0] mask,
                                 logic [7:0] dwell, logic [2:0] a, logic e, logic busy, logic sd);
        vec_t v;
        v.sel = sel; v.start = start; v.stop = stop; v.cont = cont; v.mask = mask; v.dwell = dwell;
        v.a = a; v.e = e; v.busy = busy; v.sd = sd;
        return v;
    endfunction

    task automatic drive(input bit sel, input logic start, input logic stop, input logic cont,
                         input logic [7:0] mask, input logic [7:0] dwell);
        if (sel == 1'b0) begin
            if2.start = start; if2.stop = stop; if2.continuous = cont;
            if2.chan_mask = mask; if2.dwell = dwell;
        end else begin
            if0.start = start; if0.stop = stop; if0.continuous = cont;
            if0.chan_mask = mask; if0.dwell = dwell;
        end
    endtask

    task automatic chk(input bit sel, input string name, input logic [2:0] a, input logic e,
                       input logic busy, input logic sd);
        logic [5:0] act;
        logic [5:0] exp;
        act = sel ? {if0.A, if0.E, if0.busy, if0.sweep_done}
                  : {if2.A, if2.E, if2.busy, if2.sweep_done};
        exp = {a, e, busy, sd};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got A=%0d E=%b busy=%b sd=%b, want A=%0d E=%b busy=%b sd=%b",
                     name, act[5:3], act[2], act[1], act[0], a, e, busy, sd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full single sweep, mask FF, dwell 3: each channel 3 high then 2 blank.
    task automatic sweep1(input string name);
        logic [7:0] y_act, y_exp;
        int c, ph;
        for (int k = 1; k <= 40; k++) begin
            drive(0, k == 1, 1'b0, 1'b0, 8'hFF, 8'd3);
            step();
            if (k <= 38) begin
                c  = (k - 1) / 5;
                ph = (k - 1) % 5;
                chk(0, name, 3'(c), ph < 3, 1'b1, 1'b0);
                y_exp = (ph < 3) ? (8'd1 << c) : 8'd0;
            end else begin
                chk(0, name, 3'd7, 1'b0, 1'b0, k == 39);
                y_exp = 8'd0;
            end
            y_act = if2.E ? (8'd1 << if2.A) : 8'd0;
            n_tests++;
            if (y_act !== y_exp) begin
                n_fail++;
                $display("FAIL %s_y k=%0d: got Y=%h want Y=%h", name, k, y_act, y_exp);
            end
        end
    endtask

    initial begin
        // Continuous walk 2,5,7 with dwell 0 (one cycle high), then stop on ch7's last cycle.
        tbl.push_back(mkv(0, 1, 0, 1, 8'hA4, 8'd0, 3'd2, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd2, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd2, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd7, 0, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd7, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd2, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd2, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd2, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd5, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(0, 0, 1, 1, 8'hA4, 8'd0, 3'd7, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 1, 8'hA4, 8'd0, 3'd7, 0, 0, 0));
        n_t2 = tbl.size();
        // No-blank build: mask 81, dwell 2 -> E stuck high, A 0,0,7,7,... then stop.
        tbl.push_back(mkv(1, 1, 0, 1, 8'h81, 8'd2, 3'd0, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd0, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd0, 1, 1, 1));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd0, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd7, 1, 1, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd0, 1, 1, 1));
        tbl.push_back(mkv(1, 0, 1, 1, 8'h81, 8'd2, 3'd0, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 1, 8'h81, 8'd2, 3'd0, 0, 0, 0));

        drive(0, 0, 0, 0, 8'h00, 8'd0);
        drive(1, 0, 0, 0, 8'h00, 8'd0);

        // Reset values.
        #7;
        chk(0, "reset_b2", 3'd0, 0, 0, 0);
        chk(1, "reset_b0", 3'd0, 0, 0, 0);
        #5 rst_n = 1'b1;
        step();
        chk(0, "post_reset_b2", 3'd0, 0, 0, 0);

        sweep1("sweep1");

        for (int i = 0; i < n_t2; i++) begin
            drive(tbl[i].sel, tbl[i].start, tbl[i].stop, tbl[i].cont, tbl[i].mask, tbl[i].dwell);
            step();
            chk(tbl[i].sel, $sformatf("cont_a4_v%0d", i), tbl[i].a, tbl[i].e, tbl[i].busy, tbl[i].sd);
        end

        // Stop while ch4 active in a continuous scan, then start with an empty mask.
        for (int k = 1; k <= 17; k++) begin
            drive(0, k == 1, 0, 1, 8'hFF, 8'd2);
            step();
            chk(0, $sformatf("cont_ff_k%0d", k), 3'((k - 1) / 4), ((k - 1) % 4) < 2, 1, 0);
        end
        drive(0, 0, 1, 1, 8'hFF, 8'd2); step(); chk(0, "stop_ch4", 3'd4, 0, 0, 0);
        drive(0, 0, 0, 1, 8'hFF, 8'd2); step(); chk(0, "stop_no_sd", 3'd4, 0, 0, 0);
        drive(0, 1, 0, 1, 8'h00, 8'd2); step(); chk(0, "start_mask0", 3'd4, 0, 0, 0);
        drive(0, 0, 0, 1, 8'h00, 8'd2); step(); chk(0, "start_mask0_b", 3'd4, 0, 0, 0);

        // Mask cleared during ch3 dwell: dwell completes, sweep ends, idle.
        for (int k = 1; k <= 16; k++) begin
            drive(0, k == 1, 0, 1, 8'hFF, 8'd3);
            step();
            chk(0, $sformatf("mclr_k%0d", k), 3'((k - 1) / 5), ((k - 1) % 5) < 3, 1, 0);
        end
        drive(0, 0, 0, 1, 8'h00, 8'd3); step(); chk(0, "mclr_k17", 3'd3, 1, 1, 0);
        step(); chk(0, "mclr_k18", 3'd3, 1, 1, 0);
        step(); chk(0, "mclr_done", 3'd3, 0, 0, 1);
        step(); chk(0, "mclr_idle", 3'd3, 0, 0, 0);
        drive(0, 1, 1, 1, 8'hFF, 8'd3); step(); chk(0, "start_stop", 3'd3, 0, 0, 0);
        drive(0, 0, 0, 1, 8'hFF, 8'd3); step(); chk(0, "start_stop_b", 3'd3, 0, 0, 0);

        for (int i = n_t2; i < tbl.size(); i++) begin
            drive(tbl[i].sel, tbl[i].start, tbl[i].stop, tbl[i].cont, tbl[i].mask, tbl[i].dwell);
            step();
            chk(tbl[i].sel, $sformatf("noblank_v%0d", i - n_t2), tbl[i].a, tbl[i].e, tbl[i].busy, tbl[i].sd);
        end

        // Asynchronous reset mid-BLANK (ch1) and mid-ACTIVE (ch2).
        for (int k = 1; k <= 9; k++) begin
            drive(0, k == 1, 0, 0, 8'hFF, 8'd3);
            step();
        end
        chk(0, "pre_rst_blank", 3'd1, 0, 1, 0);
        rst_n = 1'b0; #1;
        chk(0, "rst_blank", 3'd0, 0, 0, 0);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            drive(0, k == 1, 0, 0, 8'hFF, 8'd3);
            step();
        end
        chk(0, "pre_rst_active", 3'd2, 1, 1, 0);
        rst_n = 1'b0; #1;
        chk(0, "rst_active", 3'd0, 0, 0, 0);
        #2 rst_n = 1'b1;
        drive(0, 0, 0, 0, 8'hFF, 8'd3);
        step();
        chk(0, "rst_release_idle", 3'd0, 0, 0, 0);

        sweep1("sweep1_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
